dtmf_tone_gen: RTL and testbench

- Parametrised successor to the fixed single-frequency stepdown dividers in the DTMF lab.
- Accepts a 4-bit key code and drives two square waves at once:
  - one row tone (697/770/852/941 Hz)
  - one column tone (1209/1336/1477/1633 Hz)
- Each tone burst has a programmable duration, followed by a programmable silent gap.
- Sits between the Nios keypad register and the summing/PWM audio output.
- Runs from the 1 MHz system clock.

---
 rtl/dtmf_tone_gen.sv | 217 +++++++++++++++++++++
 tb/tb_dtmf_tone_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtmf_tone_gen.sv
// DTMF dual-tone generator: plays one row and one column square wave per key
// request for a programmable burst, then holds a programmable silent gap.
module dtmf_tone_gen #(
    parameter int CLK_HZ   = 1000000,
    parameter int CNT_W    = 10,
    parameter int TONE_CYC = 50000,
    parameter int GAP_CYC  = 50000,
    parameter int DUR_W    = 17
) (
    input  logic       inclk,
    input  logic       reset_n,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       abort,
    output logic       row_out,
    output logic       col_out,
    output logic       tone_active,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-period in clock cycles, rounded to nearest: round(CLK_HZ / (2*f)).
    function automatic int half_of(input int freq_hz);
        return (CLK_HZ + freq_hz) / (2 * freq_hz);
    endfunction

    localparam logic [CNT_W-1:0] ROW_HALF_0 = CNT_W'(half_of(697));
    localparam logic [CNT_W-1:0] ROW_HALF_1 = CNT_W'(half_of(770));
    localparam logic [CNT_W-1:0] ROW_HALF_2 = CNT_W'(half_of(852));
    localparam logic [CNT_W-1:0] ROW_HALF_3 = CNT_W'(half_of(941));
    localparam logic [CNT_W-1:0] COL_HALF_0 = CNT_W'(half_of(1209));
    localparam logic [CNT_W-1:0] COL_HALF_1 = CNT_W'(half_of(1336));
    localparam logic [CNT_W-1:0] COL_HALF_2 = CNT_W'(half_of(1477));
    localparam logic [CNT_W-1:0] COL_HALF_3 = CNT_W'(half_of(1633));

    localparam bit HAS_TONE  = (TONE_CYC > 0);
    localparam bit HAS_GAP   = (GAP_CYC > 0);
    localparam int TONE_LAST = HAS_TONE ? (TONE_CYC - 1) : 0;
    localparam int GAP_LAST  = HAS_GAP  ? (GAP_CYC - 1)  : 0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_key;
    logic [3:0]       w_key_nxt;
    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] w_dur_nxt;
    logic [CNT_W-1:0] r_row_cnt;
    logic [CNT_W-1:0] w_row_cnt_nxt;
    logic [CNT_W-1:0] r_col_cnt;
    logic [CNT_W-1:0] w_col_cnt_nxt;
    logic             r_row_out;
    logic             w_row_out_nxt;
    logic             r_col_out;
    logic             w_col_out_nxt;
    logic             r_tone_active;
    logic             w_tone_active_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_row_half;
    logic [CNT_W-1:0] w_col_half;
    logic [CNT_W-1:0] w_row_last;
    logic [CNT_W-1:0] w_col_last;
    logic             w_accept;
    logic             w_tone_done;
    logic             w_gap_done;

    assign w_accept    = (r_state == ST_IDLE) && key_valid && !abort;
    assign w_tone_done = (r_dur == DUR_W'(TONE_LAST));
    assign w_gap_done  = (r_dur == DUR_W'(GAP_LAST));
    assign w_row_last  = w_row_half - CNT_W'(1);
    assign w_col_last  = w_col_half - CNT_W'(1);

    // Divisor lookup from the latched key so a live key change cannot retune a burst.
    always_comb begin
        w_row_half = ROW_HALF_3;
        w_col_half = COL_HALF_3;
        case (r_key[3:2])
            2'd0:    w_row_half = ROW_HALF_0;
            2'd1:    w_row_half = ROW_HALF_1;
            2'd2:    w_row_half = ROW_HALF_2;
            default: w_row_half = ROW_HALF_3;
        endcase
        case (r_key[1:0])
            2'd0:    w_col_half = COL_HALF_0;
            2'd1:    w_col_half = COL_HALF_1;
            2'd2:    w_col_half = COL_HALF_2;
            default: w_col_half = COL_HALF_3;
        endcase
    end

    // State register.
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a zero-length tone or gap phase is skipped entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (HAS_TONE) begin
                        w_state_nxt = ST_TONE;
                    end else if (HAS_GAP) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TONE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tone_done) begin
                    w_state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
                end else begin
                    w_state_nxt = ST_TONE;
                end
            end
            ST_GAP: begin
                if (abort || w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values; dividers only run while staying in TONE,
    // so entry to TONE and every other state forces them to zero.
    always_comb begin
        w_key_nxt         = r_key;
        w_dur_nxt         = {DUR_W{1'b0}};
        w_row_cnt_nxt     = {CNT_W{1'b0}};
        w_col_cnt_nxt     = {CNT_W{1'b0}};
        w_row_out_nxt     = 1'b0;
        w_col_out_nxt     = 1'b0;
        w_tone_active_nxt = (w_state_nxt == ST_TONE);
        w_busy_nxt        = (w_state_nxt != ST_IDLE);

        if (w_accept) begin
            w_key_nxt = key;
        end else begin
            w_key_nxt = r_key;
        end

        if ((r_state != ST_IDLE) && (w_state_nxt == r_state)) begin
            w_dur_nxt = r_dur + DUR_W'(1);
        end else begin
            w_dur_nxt = {DUR_W{1'b0}};
        end

        if ((r_state == ST_TONE) && (w_state_nxt == ST_TONE)) begin
            if (r_row_cnt == w_row_last) begin
                w_row_cnt_nxt = {CNT_W{1'b0}};
                w_row_out_nxt = ~r_row_out;
            end else begin
                w_row_cnt_nxt = r_row_cnt + CNT_W'(1);
                w_row_out_nxt = r_row_out;
            end
            if (r_col_cnt == w_col_last) begin
                w_col_cnt_nxt = {CNT_W{1'b0}};
                w_col_out_nxt = ~r_col_out;
            end else begin
                w_col_cnt_nxt = r_col_cnt + CNT_W'(1);
                w_col_out_nxt = r_col_out;
            end
        end else begin
            w_row_cnt_nxt = {CNT_W{1'b0}};
            w_col_cnt_nxt = {CNT_W{1'b0}};
            w_row_out_nxt = 1'b0;
            w_col_out_nxt = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            r_key         <= 4'd0;
            r_dur         <= {DUR_W{1'b0}};
            r_row_cnt     <= {CNT_W{1'b0}};
            r_col_cnt     <= {CNT_W{1'b0}};
            r_row_out     <= 1'b0;
            r_col_out     <= 1'b0;
            r_tone_active <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_key         <= w_key_nxt;
            r_dur         <= w_dur_nxt;
            r_row_cnt     <= w_row_cnt_nxt;
            r_col_cnt     <= w_col_cnt_nxt;
            r_row_out     <= w_row_out_nxt;
            r_col_out     <= w_col_out_nxt;
            r_tone_active <= w_tone_active_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign row_out     = r_row_out;
    assign col_out     = r_col_out;
    assign tone_active = r_tone_active;
    assign busy        = r_busy;

endmodule

// File: tb/tb_dtmf_tone_gen.sv
// Bench for dtmf_tone_gen: per-cycle comparison against a burst-position model.
module tb_dtmf_tone_gen;

    localparam int TONE = 5000;
    localparam int GAP  = 2000;
    localparam int ROW_H [4] = '{717, 649, 587, 531};
    localparam int COL_H [4] = '{414, 374, 339, 306};

    logic       inclk = 1'b0;
    logic       reset_n;
    logic [3:0] key;
    logic       key_valid;
    logic       abort;
    logic       row_out;
    logic       col_out;
    logic       tone_active;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: idle flag, edges elapsed since burst entry, latched key.
    bit         m_idle = 1'b1;
    int         m_k    = 0;
    logic [3:0] m_key  = 4'd0;

    dtmf_tone_gen #(
        .CLK_HZ  (1000000),
        .CNT_W   (10),
        .TONE_CYC(TONE),
        .GAP_CYC (GAP),
        .DUR_W   (17)
    ) dut (
        .inclk      (inclk),
        .reset_n    (reset_n),
        .key        (key),
        .key_valid  (key_valid),
        .abort      (abort),
        .row_out    (row_out),
        .col_out    (col_out),
        .tone_active(tone_active),
        .busy       (busy)
    );

    always #5 inclk = ~inclk;

    // Expected {row_out, col_out, tone_active, busy} from the burst position.
    function automatic logic [3:0] model_out();
        logic r;
        logic c;
        if (m_idle) return 4'b0000;
        if (m_k < TONE) begin
            r = ((m_k / ROW_H[m_key[3:2]]) % 2) == 1;
            c = ((m_k / COL_H[m_key[1:0]]) % 2) == 1;
            return {r, c, 1'b1, 1'b1};
        end
        return 4'b0001;
    endfunction

    // Advance one clock edge, update the model with the inputs seen there, settle.
    task automatic tick();
        @(posedge inclk);
        if (!reset_n) begin
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (key_valid && !abort) begin
                m_idle = 1'b0;
                m_k    = 0;
                m_key  = key;
            end
        end else if (abort) begin
            m_idle = 1'b1;
        end else begin
            m_k++;
            if (m_k >= TONE + GAP) m_idle = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset_n = 1'b0; key = 4'd0; key_valid = 1'b0; abort = 1'b0;
        m_idle = 1'b1;
        repeat (3) @(posedge inclk);
        #1;
        got = {row_out, col_out, tone_active, busy};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0000", got);
        end
        #3 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: got %b expected %b", c, got, model_out());
            end
        end
    endtask

    task automatic test_key_one();
        logic [3:0] got;
        int tone_n = 0, busy_n = 0, row_rise = -1, col_rise = -1;
        logic prev_row = 1'b0, prev_col = 1'b0;
        key = 4'h0; key_valid = 1'b1;
        for (int c = 0; c < TONE + GAP + 3; c++) begin
            tick();
            key_valid = 1'b0;
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL key1 c=%0d: got %b expected %b", c, got, model_out());
            end
            if (tone_active) tone_n++;
            if (busy) busy_n++;
            if (row_out && !prev_row && row_rise < 0) row_rise = c;
            if (col_out && !prev_col && col_rise < 0) col_rise = c;
            prev_row = row_out; prev_col = col_out;
        end
        n_checks++;
        if (row_rise !== 717 || col_rise !== 414) begin
            n_fail++;
            $display("FAIL key1_first_rise: got row %0d col %0d expected 717 414", row_rise, col_rise);
        end
        n_checks++;
        if (tone_n !== TONE || busy_n !== TONE + GAP) begin
            n_fail++;
            $display("FAIL key1_durations: got tone %0d busy %0d expected %0d %0d",
                     tone_n, busy_n, TONE, TONE + GAP);
        end
    endtask

    task automatic test_key_d();
        logic [3:0] got;
        int row_rise = -1, col_rise = -1, gap_n = 0;
        logic prev_row = 1'b0, prev_col = 1'b0;
        key = 4'hF; key_valid = 1'b1;
        for (int c = 0; c < TONE + GAP + 3; c++) begin
            tick();
            key_valid = 1'b0;
            key = 4'($urandom_range(0, 15));
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL keyD c=%0d: got %b expected %b", c, got, model_out());
            end
            if (got == 4'b0001) gap_n++;
            if (row_out && !prev_row && row_rise < 0) row_rise = c;
            if (col_out && !prev_col && col_rise < 0) col_rise = c;
            prev_row = row_out; prev_col = col_out;
        end
        n_checks++;
        if (row_rise !== 531 || col_rise !== 306 || gap_n !== GAP) begin
            n_fail++;
            $display("FAIL keyD_timing: got row %0d col %0d gap %0d expected 531 306 %0d",
                     row_rise, col_rise, gap_n, GAP);
        end
    endtask

    task automatic test_ignore();
        logic [3:0] got;
        int busy_n = 0;
        key = 4'h0; key_valid = 1'b1;
        for (int c = 0; c < TONE + GAP + 20; c++) begin
            tick();
            key_valid = 1'b0;
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL ignore c=%0d: got %b expected %b", c, got, model_out());
            end
            if (busy) busy_n++;
            if (c == 1000 || c == TONE + 100) begin
                key = 4'h5; key_valid = 1'b1;
            end
        end
        n_checks++;
        if (busy_n !== TONE + GAP) begin
            n_fail++;
            $display("FAIL ignore_busy_total: got %0d expected %0d", busy_n, TONE + GAP);
        end
    endtask

    task automatic test_abort();
        logic [3:0] got;
        key = 4'($urandom_range(0, 15)); key_valid = 1'b1;
        for (int c = 0; c < 1250; c++) begin
            tick();
            key_valid = 1'b0;
            abort = 1'b0;
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL abort c=%0d: got %b expected %b", c, got, model_out());
            end
            if (c == 1233) abort = 1'b1;
            if (c == 1234 && got !== 4'b0000) begin
                n_fail++;
                $display("FAIL abort_to_idle: got %b expected 0000", got);
            end
        end
        abort = 1'b1; key_valid = 1'b1;
        tick();
        abort = 1'b0; key_valid = 1'b0;
        got = {row_out, col_out, tone_active, busy};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_with_key_idle: got %b expected 0000", got);
        end
        tick();
        got = {row_out, col_out, tone_active, busy};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_key_dropped: got %b expected 0000", got);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        int row_rise = -1;
        logic prev_row = 1'b0;
        key = 4'($urandom_range(0, 15)); key_valid = 1'b1;
        for (int c = 0; c <= TONE + 500; c++) begin
            tick();
            key_valid = 1'b0;
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL pre_reset c=%0d: got %b expected %b", c, got, model_out());
            end
        end
        #2 reset_n = 1'b0;
        m_idle = 1'b1;
        #1;
        got = {row_out, col_out, tone_active, busy};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b expected 0000", got);
        end
        tick();
        #3 reset_n = 1'b1;
        key = 4'($urandom_range(0, 15)); key_valid = 1'b1;
        for (int c = 0; c < TONE + GAP + 3; c++) begin
            tick();
            key_valid = 1'b0;
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL post_reset c=%0d: got %b expected %b", c, got, model_out());
            end
            if (row_out && !prev_row && row_rise < 0) row_rise = c;
            prev_row = row_out;
        end
        n_checks++;
        if (row_rise !== ROW_H[m_key[3:2]]) begin
            n_fail++;
            $display("FAIL post_reset_first_rise: got %0d expected %0d", row_rise, ROW_H[m_key[3:2]]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        int idle_len = 0, gaps_seen = 0;
        bit seen_busy = 1'b0;
        logic prev_busy = 1'b0;
        key = 4'($urandom_range(0, 15)); key_valid = 1'b1;
        for (int c = 0; c < 2 * (TONE + GAP + 1) + 5; c++) begin
            tick();
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL b2b c=%0d: got %b expected %b", c, got, model_out());
            end
            if (!busy) idle_len++;
            if (busy && !prev_busy && seen_busy) begin
                gaps_seen++;
                n_checks++;
                if (idle_len !== 1) begin
                    n_fail++;
                    $display("FAIL b2b_idle_len: got %0d expected 1", idle_len);
                end
            end
            if (busy) begin
                seen_busy = 1'b1;
                idle_len = 0;
            end
            prev_busy = busy;
        end
        key_valid = 1'b0;
        n_checks++;
        if (gaps_seen !== 2) begin
            n_fail++;
            $display("FAIL b2b_restarts: got %0d expected 2", gaps_seen);
        end
        for (int c = 0; c < TONE + GAP + 3; c++) begin
            tick();
            got = {row_out, col_out, tone_active, busy};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL b2b_drain c=%0d: got %b expected %b", c, got, model_out());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got;
        int stop;
        for (int it = 0; it < 3; it++) begin
            key = 4'($urandom_range(0, 15)); key_valid = 1'b1;
            stop = $urandom_range(0, TONE + GAP + 100);
            for (int c = 0; c < TONE + GAP + 4; c++) begin
                tick();
                key_valid = 1'b0;
                abort = 1'b0;
                got = {row_out, col_out, tone_active, busy};
                n_checks++;
                if (got !== model_out()) begin
                    n_fail++;
                    $display("FAIL random it=%0d c=%0d: got %b expected %b", it, c, got, model_out());
                end
                if (c == stop) abort = 1'b1;
                if (c < TONE + GAP - 10 && $urandom_range(0, 499) == 0) begin
                    key = 4'($urandom_range(0, 15)); key_valid = 1'b1;
                end
            end
            abort = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_key_one();
        test_key_d();
        test_ignore();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
